// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction-memory request, holds one fetched
// instruction for decode, and tracks redirects, including a request still in flight when
// a redirect arrives.
module fetch_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             stall,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_instr,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {
        StReset,
        StFetch,
        StDrop
    } state_e;

    localparam logic [WIDTH-1:0] PcStep    = WIDTH'(4);
    localparam logic [WIDTH-1:0] CountStep = WIDTH'(1);
    localparam logic [WIDTH-1:0] AlignMask = ~WIDTH'(3);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    // Address of the request being abandoned after a redirect.
    logic [WIDTH-1:0] drop_addr_q, drop_addr_d;
    logic             if_valid_q, if_valid_d;
    logic [WIDTH-1:0] if_instr_q, if_instr_d;
    logic [WIDTH-1:0] if_pc_q, if_pc_d;
    logic [WIDTH-1:0] fetch_count_q, fetch_count_d;

    logic consume;
    logic fire;

    // Memory request: in FETCH only when the output buffer can take a new word.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            StFetch: imem_req = !if_valid_q || !stall;
            StDrop: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
            end
            default: imem_req = 1'b0;
        endcase
    end

    assign consume = if_valid_q && !stall;
    assign fire    = imem_req && imem_ack;

    // Next-state logic: redirect wins over everything, and an in-flight request is dropped.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_addr_d   = drop_addr_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                if (redirect_valid) begin
                    pc_d       = redirect_target & AlignMask;
                    if_valid_d = 1'b0;
                    if (imem_req && !imem_ack) begin
                        state_d     = StDrop;
                        drop_addr_d = pc_q;
                    end
                end else begin
                    if (consume) begin
                        fetch_count_d = fetch_count_q + CountStep;
                        if_valid_d    = 1'b0;
                    end
                    if (fire) begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        pc_d       = pc_q + PcStep;
                    end
                end
            end
            StDrop: begin
                if (redirect_valid) begin
                    pc_d = redirect_target & AlignMask;
                end
                // The abandoned request completes; its data is thrown away.
                if (imem_ack) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StReset;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StReset;
            pc_q          <= RESET_PC & AlignMask;
            drop_addr_q   <= '0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_addr_q   <= drop_addr_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a vector table for steady fetch and stall, hand sequences for
// redirect, wrap and reset corners, then random traffic checked against a reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] fetch_count;

    fetch_ctrl #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory stimulus: fixed latency returning addr as data, or random acks/data.
    bit rnd_mode = 1'b0;
    int mem_lat  = 1;
    int mem_wait = 0;

    // Reference model: what the fetch unit must look like from outside.
    bit          m_boot;       // first cycle after reset, no request yet
    bit          m_drop;       // old request still owed an ack, its data unwanted
    logic [31:0] m_drop_addr;
    logic [31:0] m_pc;
    bit          m_bv;
    logic [31:0] m_bi, m_bp;
    logic [31:0] m_cnt;

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_req(input logic s);
        if (m_boot) return 1'b0;
        if (m_drop) return 1'b1;
        return !m_bv || !s;
    endfunction

    task automatic drive(input logic s, input logic rv, input logic [31:0] tgt, input logic r);
        rst             = r;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = tgt;
        #1;
        if (rnd_mode) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
        end else begin
            imem_ack   = imem_req && (mem_wait >= mem_lat - 1);
            imem_rdata = imem_addr;
        end
        #1;
    endtask

    task automatic tick();
        bit req_m;
        req_m = model_req(stall);
        if (!rst) begin
            m_boot = 1'b1; m_drop = 1'b0; m_pc = 32'h0; m_drop_addr = 32'h0;
            m_bv = 1'b0; m_bi = 32'h0; m_bp = 32'h0; m_cnt = 32'h0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_drop) begin
            if (redirect_valid) m_pc = redirect_target & ~32'h3;
            if (imem_ack) m_drop = 1'b0;
        end else if (redirect_valid) begin
            if (req_m && !imem_ack) begin
                m_drop      = 1'b1;
                m_drop_addr = m_pc;
            end
            m_pc = redirect_target & ~32'h3;
            m_bv = 1'b0;
        end else begin
            if (m_bv && !stall) begin
                m_cnt = m_cnt + 32'd1;
                m_bv  = 1'b0;
            end
            if (req_m && imem_ack) begin
                m_bv = 1'b1;
                m_bi = imem_rdata;
                m_bp = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
        if (imem_req && !imem_ack) mem_wait++;
        else mem_wait = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0); tick();
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0,  32'd0};
        vecs[1] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0,  32'd0};
        vecs[2] = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h0,  32'd0};
        vecs[3] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h4,  32'd1};
        vecs[4] = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h8,  32'd2};
        vecs[5] = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h8,  32'd2};
        vecs[6] = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h8,  32'd2};
        vecs[7] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h8,  32'd2};
        vecs[8] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hC,  32'd3};

        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state while rst is still low.
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        tick();

        // Zero-wait streaming followed by a three-cycle stall.
        mem_lat = 1;
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].stall, 1'b0, 32'h0, 1'b1);
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_count", i), fetch_count, vecs[i].exp_cnt);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i), if_pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d_instr", i), if_instr, vecs[i].exp_pc);
            end
            tick();
        end

        // Reset while a slow request to 0x14 is outstanding.
        mem_lat = 4;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("r37_addr", imem_addr, 32'h14);
        chk("r37_pc", if_pc, 32'h10);
        chk("r37_count4", fetch_count, 32'd4);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("r37_pending", 32'(imem_req), 32'd1);
        chk("r37_count5", fetch_count, 32'd5);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("r37_req_off", 32'(imem_req), 32'd0);
        chk("r37_valid_off", 32'(if_valid), 32'd0);
        chk("r37_count_clr", fetch_count, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("r37_restart_req", 32'(imem_req), 32'd1);
        chk("r37_restart_addr", imem_addr, 32'h0);
        tick();

        // Redirect to 0x100 while a latency-3 request to 0x10 is in flight.
        do_reset();
        mem_lat = 1;
        drive(1'b0, 1'b0, 32'h0, 1'b1); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1); tick();
        drive(1'b1, 1'b1, 32'h10, 1'b1);
        chk("r34_stalled_req", 32'(imem_req), 32'd0);
        tick();
        mem_lat = 3;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("r34_req10", imem_addr, 32'h10);
        chk("r34_flushed", 32'(if_valid), 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'h100, 1'b1);
        chk("r34_hold1", imem_addr, 32'h10);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("r34_hold2", imem_addr, 32'h10);
        chk("r34_hold2_req", 32'(imem_req), 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("r34_new_addr", imem_addr, 32'h100);
        chk("r34_discard", 32'(if_valid), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("r34_valid", 32'(if_valid), 32'd1);
        chk("r34_pc", if_pc, 32'h100);
        chk("r34_instr", if_instr, 32'h100);
        chk("r34_count", fetch_count, 32'd0);
        tick();

        // Misaligned redirect coincident with an ack.
        do_reset();
        mem_lat = 1;
        drive(1'b0, 1'b0, 32'h0, 1'b1); tick();
        drive(1'b0, 1'b1, 32'h203, 1'b1); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("r35_addr", imem_addr, 32'h200);
        chk("r35_discard", 32'(if_valid), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("r35_pc", if_pc, 32'h200);
        chk("r35_next", imem_addr, 32'h204);
        tick();

        // PC wrap at the top of the address space.
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1); tick();
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("r36_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("r36_wrap", imem_addr, 32'h0);
        chk("r36_pc", if_pc, 32'hFFFF_FFFC);
        tick();

        // Random traffic against the reference model.
        do_reset();
        rnd_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0), $urandom,
                  1'($urandom_range(0, 99) != 0));
            chk("rnd_req", 32'(imem_req), 32'(model_req(stall)));
            chk("rnd_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
            chk("rnd_valid", 32'(if_valid), 32'(m_bv));
            chk("rnd_count", fetch_count, m_cnt);
            if (m_bv) begin
                chk("rnd_pc", if_pc, m_bp);
                chk("rnd_instr", if_instr, m_bi);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, as the address/data width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, as the first fetch address.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low: asserted when rst==0, sampled only at posedge clk.
REQ-005 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-006 SHALL have port imem_addr  output  WIDTH  fetch address, word aligned.
REQ-007 SHALL have port imem_ack  input  1  memory completion; accepted only while imem_req==1.
REQ-008 SHALL have port imem_rdata  input  WIDTH  instruction word, valid when imem_ack==1.
REQ-009 SHALL have port redirect_valid  input  1  single-cycle pulse; resolved branch/jal/jalr taken.
REQ-010 SHALL have port redirect_target  input  WIDTH  new PC for the redirect.
REQ-011 SHALL have port stall  input  1  decode cannot accept the instruction this cycle.
REQ-012 SHALL have port if_valid  output  1  if_instr/if_pc hold a fetched instruction.
REQ-013 SHALL have port if_instr  output  WIDTH  fetched instruction.
REQ-014 SHALL have port if_pc  output  WIDTH  address of if_instr.
REQ-015 SHALL have port fetch_count  output  WIDTH  count of instructions delivered to decode.

Function
REQ-016 SHALL implement states RESET, FETCH, DROP; RESET is entered by reset and left on the first cycle with rst==1, going to FETCH.
REQ-017 SHALL hold internal pc register; imem_addr SHALL equal pc in FETCH and the outstanding address in DROP.
REQ-018 SHALL drive imem_req=1 in FETCH when the output buffer is free (if_valid==0, or if_valid==1 and stall==0), and in DROP unconditionally; imem_req=0 otherwise.
REQ-019 SHALL keep imem_addr stable while imem_req==1 and imem_ack==0 (no address change mid-request).
REQ-020 SHALL, on imem_ack in FETCH without redirect: next cycle if_valid=1, if_instr=imem_rdata, if_pc=pc, pc=pc+4 (modulo 2^WIDTH, wrap 32'hFFFF_FFFC -> 0).
REQ-021 SHALL support back-to-back fetches: a new request with pc+4 is issued the cycle after ack if the buffer is free (one instruction per cycle with zero-wait memory).
REQ-022 SHALL hold if_valid, if_instr, if_pc unchanged while stall==1 and no redirect.
REQ-023 SHALL clear if_valid the cycle after consumption (if_valid && !stall) unless a new ack refills it in that same cycle.
REQ-024 SHALL increment fetch_count by 1 on every consumption cycle, wrapping to 0 after all-ones.
REQ-025 SHALL, on redirect_valid: set pc=redirect_target with bits[1:0] forced to 0, clear if_valid next cycle (no count increment for a flushed instruction).
REQ-026 SHALL, on redirect while imem_req==1 and imem_ack==0, enter DROP keeping the old address; the ack ending DROP SHALL be discarded and the state SHALL return to FETCH at the redirected pc.
REQ-027 SHALL, on redirect coincident with imem_ack, discard imem_rdata and stay in FETCH at the redirected pc.
REQ-028 SHALL, on redirect during DROP, update pc to the newest target and remain in DROP.
REQ-029 SHALL give redirect priority over stall, and stall no effect on pc.

Reset
REQ-030 SHALL, while rst==0 at posedge clk: state=RESET, pc=RESET_PC, imem_req=0, if_valid=0, if_instr=0, if_pc=0, fetch_count=0.
REQ-031 SHALL abort any outstanding request on reset mid-operation; an ack arriving while in RESET SHALL be ignored.

Verification
REQ-032 Reset release, zero-wait memory returning addr as data, stall=0 -> imem_addr 0,4,8,... on consecutive cycles; if_pc/if_instr 0,4,8 one cycle later; fetch_count 3 after three deliveries.
REQ-033 stall=1 for 3 cycles with if_pc=8 -> if_pc stays 8, imem_req=0, fetch_count frozen; resumes at 12 after stall drops.
REQ-034 Memory latency 3, redirect_target=0x100 one cycle after request to 0x10 -> imem_addr stays 0x10 until ack, data discarded, next request 0x100, if_pc 0x100.
REQ-035 redirect_target=0x203 coincident with ack -> data discarded, next imem_addr 0x200.
REQ-036 pc=0xFFFF_FFFC fetched -> next imem_addr 0x0000_0000.
REQ-037 rst=0 while a request is outstanding -> next cycle imem_req=0, if_valid=0, fetch_count=0; after release first address RESET_PC.
